hamming_codec: RTL and testbench

HAMMING_CODEC -- requirements
Module: hamming_codec

---
 rtl/hamming_codec.sv | 153 +++++++++++++++
 tb/tb_hamming_codec.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_codec.sv
// Single-cycle Hamming SEC encoder/decoder with a valid/ready output register.
// Define HAMMING_ERR_CNT_EN to build the saturating corrected/uncorrectable error counters.
module hamming_codec #(
    parameter int DATA_W = 8,
    localparam int PAR_W = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + PAR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic              out_err_corr,
    output logic              out_err_uncorr,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              cnt_clr,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt
);

    function automatic logic is_par_pos(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    function automatic logic [PAR_W-1:0] syndrome_of(input logic [CODE_W-1:0] cw);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 0; i < CODE_W; i++)
            if (cw[i]) s = s ^ PAR_W'(i + 1);
        return s;
    endfunction

    function automatic logic [CODE_W-1:0] scatter(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] cw;
        int j;
        cw = '0;
        j = 0;
        for (int i = 0; i < CODE_W; i++) begin
            if (!is_par_pos(i + 1)) begin
                cw[i] = d[j];
                j++;
            end
        end
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 0; i < CODE_W; i++) begin
            if (!is_par_pos(i + 1)) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    logic              accept;
    logic [CODE_W-1:0] code_enc;
    logic [PAR_W-1:0]  syn_enc;
    logic [PAR_W-1:0]  syn_dec;
    logic [CODE_W-1:0] fixed;
    logic              dec_corr;
    logic              dec_uncorr;
    logic [CODE_W-1:0] nxt_data;
    logic [PAR_W-1:0]  nxt_syn;
    logic              nxt_corr;
    logic              nxt_uncorr;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // Parity slots are zero in the scattered word, so its syndrome is exactly the parity vector.
        code_enc = scatter(in_data[DATA_W-1:0]);
        syn_enc  = syndrome_of(code_enc);
        for (int k = 0; k < PAR_W; k++)
            code_enc[(1 << k) - 1] = syn_enc[k];

        syn_dec    = syndrome_of(in_data);
        fixed      = in_data;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        if (syn_dec != '0) begin
            if (int'(syn_dec) <= CODE_W) begin
                fixed[int'(syn_dec) - 1] = ~in_data[int'(syn_dec) - 1];
                dec_corr = 1'b1;
            end else begin
                dec_uncorr = 1'b1;
            end
        end

        if (in_mode) begin
            nxt_data   = CODE_W'(extract(fixed));
            nxt_syn    = syn_dec;
            nxt_corr   = dec_corr;
            nxt_uncorr = dec_uncorr;
        end else begin
            nxt_data   = code_enc;
            nxt_syn    = '0;
            nxt_corr   = 1'b0;
            nxt_uncorr = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_err_corr   <= 1'b0;
            out_err_uncorr <= 1'b0;
            out_syndrome   <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_data       <= nxt_data;
            out_err_corr   <= nxt_corr;
            out_err_uncorr <= nxt_uncorr;
            out_syndrome   <= nxt_syn;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (accept && in_mode) begin
            if (dec_corr && corr_cnt != 16'hFFFF)
                corr_cnt <= corr_cnt + 16'd1;
            if (dec_uncorr && uncorr_cnt != 16'hFFFF)
                uncorr_cnt <= uncorr_cnt + 16'd1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_codec.sv
// Directed bench for hamming_codec (DATA_W=8): vector table, backpressure stream, reset, counters.
module tb_hamming_codec;

    localparam int CODE_W = 12;
    localparam int PAR_W  = 4;
`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_mode = 1'b0;
    logic [CODE_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CODE_W-1:0] out_data;
    logic              out_err_corr;
    logic              out_err_uncorr;
    logic [PAR_W-1:0]  out_syndrome;
    logic              cnt_clr = 1'b0;
    logic [15:0]       corr_cnt;
    logic [15:0]       uncorr_cnt;

    hamming_codec #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err_corr(out_err_corr), .out_err_uncorr(out_err_uncorr),
        .out_syndrome(out_syndrome),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [11:0] din;
        logic [11:0] exp_data;
        logic        exp_corr;
        logic        exp_uncorr;
        logic [3:0]  exp_syn;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    vec_t vecs[12];
    logic [11:0] s_in[4];
    logic [11:0] s_exp[4];

    initial begin
        vecs[0]  = '{1'b0, 12'h0A5, 12'hA27, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 12'hA07, 12'h0A5, 1'b1, 1'b0, 4'd6};
        vecs[2]  = '{1'b1, 12'hB2F, 12'h0B5, 1'b0, 1'b1, 4'd13};
        vecs[3]  = '{1'b1, 12'hA27, 12'h0A5, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 12'h0FF, 12'hF77, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b0, 12'hF01, 12'h007, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 12'h006, 12'h001, 1'b1, 1'b0, 4'd1};
        vecs[8]  = '{1'b1, 12'h807, 12'h001, 1'b1, 1'b0, 4'd12};
        vecs[9]  = '{1'b1, 12'h00F, 12'h001, 1'b1, 1'b0, 4'd4};
        vecs[10] = '{1'b1, 12'h803, 12'h080, 1'b0, 1'b1, 4'd15};
        vecs[11] = '{1'b1, 12'hF77, 12'h0FF, 1'b0, 1'b0, 4'd0};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flags", {30'd0, out_err_corr, out_err_uncorr}, 32'd0);
        chk("rst_syn", 32'(out_syndrome), 32'd0);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table, one word per transaction
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_mode  = vecs[i].mode;
            in_data  = vecs[i].din;
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_corr", i), 32'(out_err_corr), 32'(vecs[i].exp_corr));
            chk($sformatf("v%0d_uncorr", i), 32'(out_err_uncorr), 32'(vecs[i].exp_uncorr));
            chk($sformatf("v%0d_syn", i), 32'(out_syndrome), 32'(vecs[i].exp_syn));
        end
        @(posedge clk); #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("tbl_corr_cnt", 32'(corr_cnt), CNT_EN ? 32'd4 : 32'd0);
        chk("tbl_uncorr_cnt", 32'(uncorr_cnt), CNT_EN ? 32'd2 : 32'd0);

        // Backpressure stream: 4 encode words, out_ready low for cycles 1..3
        s_in[0] = 12'h0A5; s_exp[0] = 12'hA27;
        s_in[1] = 12'h0FF; s_exp[1] = 12'hF77;
        s_in[2] = 12'h000; s_exp[2] = 12'h000;
        s_in[3] = 12'h001; s_exp[3] = 12'h007;
        begin
            int idx_in = 0;
            int idx_out = 0;
            int blocked_seen = 0;
            for (int cyc = 0; cyc < 20 && idx_out < 4; cyc++) begin
                in_mode   = 1'b0;
                in_valid  = (idx_in < 4);
                in_data   = (idx_in < 4) ? s_in[idx_in] : 12'h000;
                out_ready = !(cyc >= 1 && cyc <= 3);
                #1;
                if (out_valid && !out_ready) begin
                    blocked_seen++;
                    chk("blk_in_ready", 32'(in_ready), 32'd0);
                    chk("blk_hold_data", 32'(out_data), 32'(s_exp[idx_out]));
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("stream_out%0d", idx_out), 32'(out_data), 32'(s_exp[idx_out]));
                    idx_out++;
                end
                if (in_valid && in_ready) idx_in++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk("stream_delivered", 32'(idx_out), 32'd4);
            chk("stream_blocked_cycles", 32'(blocked_seen), 32'd3);
        end

        // Asynchronous reset while a result is held
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = 1'b1; in_data = 12'hA07; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_out", 32'(out_valid), 32'd0);
        end

        // Counter saturation and clear priority
        in_valid = 1'b1; in_mode = 1'b1; in_data = 12'hA07; cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_ignored_or_zero", 32'(corr_cnt), 32'd0);
        if (CNT_EN) begin
            repeat (65537) @(posedge clk);
            #1;
            chk("sat_corr_cnt", 32'(corr_cnt), 32'hFFFF);
            chk("sat_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
            cnt_clr = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            in_valid = 1'b0;
            chk("clr_wins_corr", 32'(corr_cnt), 32'd0);
        end else begin
            repeat (5) @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("nomacro_corr_cnt", 32'(corr_cnt), 32'd0);
            chk("nomacro_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
